// File: rtl/fdiv_issue_queue_pkg.sv
// Shared types for the FP divide/sqrt issue queue: entry layout, issue fields, ROB age compare.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fdiv_issue_queue_pkg;

    localparam int ROB_WIDTH  = 6;
    localparam int PREG_WIDTH = 7;
    localparam int XLEN       = 64;
    localparam int IQ_DEPTH   = 8;

    typedef logic [ROB_WIDTH-1:0]  rob_idx_t;
    typedef logic [PREG_WIDTH-1:0] preg_t;

    typedef struct packed {
        logic       div;
        logic       db;
        logic [2:0] rm;
    } fdiv_issue_t;

    typedef struct packed {
        logic        vld;
        rob_idx_t    rob_idx;
        preg_t       rd;
        preg_t       rs1;
        preg_t       rs2;
        logic        rdy1;
        logic        rdy2;
        fdiv_issue_t op;
    } fdiv_iq_entry_t;

    typedef struct packed {
        rob_idx_t rob_idx;
        preg_t    rd;
    } ex_status_t;

    // a strictly older than b; MSB is the ROB wrap bit, so order flips when wraps differ
    function automatic logic loop_older(input rob_idx_t a, input rob_idx_t b);
        if (a[ROB_WIDTH-1] == b[ROB_WIDTH-1]) begin
            return a[ROB_WIDTH-2:0] < b[ROB_WIDTH-2:0];
        end
        return a[ROB_WIDTH-2:0] > b[ROB_WIDTH-2:0];
    endfunction

endpackage

// File: rtl/fdiv_issue_queue_age_matrix.sv
// Age matrix: tracks allocation order of queue slots and reports the oldest ready slot one-hot.
// Latency: oldest is combinational from ready; order updates at the allocate edge.
// Backpressure: none; caller gates allocation and selection.
module iq_age_matrix #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DEPTH-1:0] alloc,
    input  logic [DEPTH-1:0] free,
    input  logic [DEPTH-1:0] valid,
    input  logic [DEPTH-1:0] ready,
    output logic [DEPTH-1:0] oldest
);

    // age_q[i][j] = 1 means slot i was allocated before slot j
    logic [DEPTH-1:0][DEPTH-1:0] age_q;
    logic [DEPTH-1:0][DEPTH-1:0] age_d;

    always_comb begin
        age_d = age_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (alloc[k]) begin
                age_d[k] = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    age_d[i][k] = valid[i] & ~free[i] & (i != k);
                end
            end
        end
    end

    // Stale bits of invalid slots are harmless: ready implies valid
    always_comb begin
        oldest = '0;
        for (int i = 0; i < DEPTH; i++) begin
            oldest[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready[j] && age_q[j][i]) begin
                    oldest[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/fdiv_issue_queue.sv
// Issue queue for the non-pipelined FP div/sqrt unit: wakeup tracking, oldest-ready select, regfile read.
// Latency: ready -> rf_en same cycle, fdiv_en next cycle; one op in the unit until done or killed.
// Backpressure: dis_ready low when every slot is valid; issue held while the unit is busy.
module fdiv_issue_queue
    import fdiv_issue_queue_pkg::*;
#(
    parameter int DEPTH      = IQ_DEPTH,
    parameter int WAKE_PORTS = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             dis_en,
    output logic                             dis_ready,
    input  logic [ROB_WIDTH-1:0]             dis_rob_idx,
    input  logic [PREG_WIDTH-1:0]            dis_rd,
    input  logic [PREG_WIDTH-1:0]            dis_rs1,
    input  logic [PREG_WIDTH-1:0]            dis_rs2,
    input  logic                             dis_rdy1,
    input  logic                             dis_rdy2,
    input  logic                             dis_div,
    input  logic                             dis_db,
    input  logic [2:0]                       dis_rm,
    input  logic [WAKE_PORTS-1:0]            wk_en,
    input  logic [WAKE_PORTS*PREG_WIDTH-1:0] wk_rd,
    output logic                             rf_en,
    output logic [PREG_WIDTH-1:0]            rf_rs1,
    output logic [PREG_WIDTH-1:0]            rf_rs2,
    input  logic [XLEN-1:0]                  rf_data1,
    input  logic [XLEN-1:0]                  rf_data2,
    output logic                             fdiv_en,
    output ex_status_t                       fdiv_status,
    output logic                             fdiv_div,
    output logic                             fdiv_db,
    output logic [2:0]                       fdiv_rm,
    output logic [XLEN-1:0]                  fdiv_rs1_data,
    output logic [XLEN-1:0]                  fdiv_rs2_data,
    input  logic                             fdiv_done,
    input  logic                             redirect,
    input  logic [ROB_WIDTH-1:0]             redirect_idx
);

    fdiv_iq_entry_t   ent_q [DEPTH];
    fdiv_iq_entry_t   ent_d [DEPTH];
    fdiv_iq_entry_t   sel_ent;
    logic [DEPTH-1:0] vld_vec, rdy_vec, alloc_oh, free_vec, sel_oh;
    logic             busy_q, busy_d;
    logic             s1_vld_q, s1_vld_d;
    ex_status_t       s1_status_q, s1_status_d;
    fdiv_issue_t      s1_op_q, s1_op_d;
    logic             sel_fire, alloc_fire, s1_kill;

    function automatic logic woken(input logic [WAKE_PORTS-1:0]            en,
                                   input logic [WAKE_PORTS*PREG_WIDTH-1:0] rd,
                                   input logic [PREG_WIDTH-1:0]            rs);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < WAKE_PORTS; p++) begin
            hit |= en[p] && (rd[p*PREG_WIDTH +: PREG_WIDTH] == rs);
        end
        return hit;
    endfunction

    always_comb begin
        vld_vec = '0;
        rdy_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vld_vec[i] = ent_q[i].vld;
            rdy_vec[i] = ent_q[i].vld & ent_q[i].rdy1 & ent_q[i].rdy2;
        end
    end

    assign dis_ready  = ~&vld_vec;
    assign alloc_fire = dis_en & dis_ready & ~redirect;
    // A redirect cycle never selects, so a squashed op cannot reach S1
    assign sel_fire   = ~busy_q & ~redirect & (|rdy_vec);

    always_comb begin
        logic found;
        found    = 1'b0;
        alloc_oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!ent_q[i].vld && !found) begin
                alloc_oh[i] = alloc_fire;
                found       = 1'b1;
            end
        end
    end

    iq_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk    (clk),
        .rst    (rst),
        .alloc  (alloc_oh),
        .free   (free_vec),
        .valid  (vld_vec),
        .ready  (rdy_vec),
        .oldest (sel_oh)
    );

    always_comb begin
        sel_ent = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                sel_ent = ent_q[i];
            end
        end
    end

    always_comb begin
        free_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].vld) begin
                if (woken(wk_en, wk_rd, ent_q[i].rs1)) ent_d[i].rdy1 = 1'b1;
                if (woken(wk_en, wk_rd, ent_q[i].rs2)) ent_d[i].rdy2 = 1'b1;
                if ((sel_fire && sel_oh[i]) ||
                    (redirect && !loop_older(ent_q[i].rob_idx, redirect_idx))) begin
                    ent_d[i].vld = 1'b0;
                    free_vec[i]  = 1'b1;
                end
            end
            if (alloc_oh[i]) begin
                ent_d[i].vld     = 1'b1;
                ent_d[i].rob_idx = dis_rob_idx;
                ent_d[i].rd      = dis_rd;
                ent_d[i].rs1     = dis_rs1;
                ent_d[i].rs2     = dis_rs2;
                ent_d[i].rdy1    = dis_rdy1 | woken(wk_en, wk_rd, dis_rs1);
                ent_d[i].rdy2    = dis_rdy2 | woken(wk_en, wk_rd, dis_rs2);
                ent_d[i].op.div  = dis_div;
                ent_d[i].op.db   = dis_db;
                ent_d[i].op.rm   = dis_rm;
            end
        end
    end

    // s1_status_q keeps the in-flight op's ROB index until the next select
    assign s1_kill = redirect & ~loop_older(s1_status_q.rob_idx, redirect_idx);

    always_comb begin
        busy_d      = busy_q;
        s1_vld_d    = sel_fire;
        s1_status_d = s1_status_q;
        s1_op_d     = s1_op_q;
        if (fdiv_done)         busy_d = 1'b0;
        if (busy_q && s1_kill) busy_d = 1'b0;
        if (sel_fire) begin
            busy_d              = 1'b1;
            s1_status_d.rob_idx = sel_ent.rob_idx;
            s1_status_d.rd      = sel_ent.rd;
            s1_op_d             = sel_ent.op;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            busy_q      <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_status_q <= '0;
            s1_op_q     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            busy_q      <= busy_d;
            s1_vld_q    <= s1_vld_d;
            s1_status_q <= s1_status_d;
            s1_op_q     <= s1_op_d;
        end
    end

    assign rf_en         = sel_fire;
    assign rf_rs1        = sel_ent.rs1;
    assign rf_rs2        = sel_ent.rs2;
    assign fdiv_en       = s1_vld_q & ~s1_kill;
    assign fdiv_status   = s1_status_q;
    assign fdiv_div      = s1_op_q.div;
    assign fdiv_db       = s1_op_q.db;
    assign fdiv_rm       = s1_op_q.rm;
    assign fdiv_rs1_data = s1_vld_q ? rf_data1 : '0;
    assign fdiv_rs2_data = s1_vld_q ? rf_data2 : '0;

    a_dis_when_full: assert property (@(posedge clk) disable iff (!rst) !(dis_en && !dis_ready));

endmodule

// File: tb/tb_fdiv_issue_queue.sv
// Directed bench for fdiv_issue_queue: issue latency, oldest-ready ordering, full, redirect, ROB wrap, reset.
module tb_fdiv_issue_queue;
    import fdiv_issue_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        dis_en, dis_ready, dis_rdy1, dis_rdy2, dis_div, dis_db;
    logic [5:0]  dis_rob_idx;
    logic [6:0]  dis_rd, dis_rs1, dis_rs2;
    logic [2:0]  dis_rm;
    logic [3:0]  wk_en;
    logic [27:0] wk_rd;
    logic        rf_en;
    logic [6:0]  rf_rs1, rf_rs2;
    logic [63:0] rf_data1, rf_data2;
    logic        fdiv_en, fdiv_div, fdiv_db, fdiv_done, redirect;
    ex_status_t  fdiv_status;
    logic [2:0]  fdiv_rm;
    logic [63:0] fdiv_rs1_data, fdiv_rs2_data;
    logic [5:0]  redirect_idx;

    int total = 0;
    int bad   = 0;

    fdiv_issue_queue #(.DEPTH(8), .WAKE_PORTS(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .dis_en        (dis_en),
        .dis_ready     (dis_ready),
        .dis_rob_idx   (dis_rob_idx),
        .dis_rd        (dis_rd),
        .dis_rs1       (dis_rs1),
        .dis_rs2       (dis_rs2),
        .dis_rdy1      (dis_rdy1),
        .dis_rdy2      (dis_rdy2),
        .dis_div       (dis_div),
        .dis_db        (dis_db),
        .dis_rm        (dis_rm),
        .wk_en         (wk_en),
        .wk_rd         (wk_rd),
        .rf_en         (rf_en),
        .rf_rs1        (rf_rs1),
        .rf_rs2        (rf_rs2),
        .rf_data1      (rf_data1),
        .rf_data2      (rf_data2),
        .fdiv_en       (fdiv_en),
        .fdiv_status   (fdiv_status),
        .fdiv_div      (fdiv_div),
        .fdiv_db       (fdiv_db),
        .fdiv_rm       (fdiv_rm),
        .fdiv_rs1_data (fdiv_rs1_data),
        .fdiv_rs2_data (fdiv_rs2_data),
        .fdiv_done     (fdiv_done),
        .redirect      (redirect),
        .redirect_idx  (redirect_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic dispatch(input logic [5:0] rob, input logic [6:0] rd, input logic [6:0] rs1,
                            input logic [6:0] rs2, input logic r1, input logic r2);
        dis_en      = 1'b1;
        dis_rob_idx = rob;
        dis_rd      = rd;
        dis_rs1     = rs1;
        dis_rs2     = rs2;
        dis_rdy1    = r1;
        dis_rdy2    = r2;
        tick();
        dis_en      = 1'b0;
    endtask

    task automatic wake(input int port, input logic [6:0] preg);
        wk_en[port]         = 1'b1;
        wk_rd[port*7 +: 7]  = preg;
        tick();
        wk_en               = '0;
    endtask

    initial begin
        rst = 1'b0; dis_en = 1'b0; dis_rob_idx = '0; dis_rd = '0; dis_rs1 = '0; dis_rs2 = '0;
        dis_rdy1 = 1'b0; dis_rdy2 = 1'b0; dis_div = 1'b0; dis_db = 1'b0; dis_rm = '0;
        wk_en = '0; wk_rd = '0; fdiv_done = 1'b0; redirect = 1'b0; redirect_idx = '0;
        rf_data1 = 64'hA5A5; rf_data2 = 64'h5A5A;
        #12;
        chk("rst_dis_ready", dis_ready, 1);
        chk("rst_rf_en", rf_en, 0);
        chk("rst_fdiv_en", fdiv_en, 0);
        chk("rst_status", fdiv_status, 0);
        chk("rst_data1", fdiv_rs1_data, 0);
        rst = 1'b1;
        tick();

        // basic issue: rob 5, both sources ready
        dis_div = 1'b1; dis_db = 1'b1; dis_rm = 3'b010;
        dispatch(6'd5, 7'd10, 7'd1, 7'd2, 1'b1, 1'b1);
        settle();
        chk("t1_rf_en", rf_en, 1);
        chk("t1_rf_rs1", rf_rs1, 1);
        chk("t1_rf_rs2", rf_rs2, 2);
        chk("t1_fdiv_en_early", fdiv_en, 0);
        rf_data1 = 64'h1111; rf_data2 = 64'h2222;
        tick(); settle();
        chk("t1_fdiv_en", fdiv_en, 1);
        chk("t1_rob", fdiv_status.rob_idx, 5);
        chk("t1_rd", fdiv_status.rd, 10);
        chk("t1_div", fdiv_div, 1);
        chk("t1_db", fdiv_db, 1);
        chk("t1_rm", fdiv_rm, 3'b010);
        chk("t1_data1", fdiv_rs1_data, 64'h1111);
        chk("t1_data2", fdiv_rs2_data, 64'h2222);
        chk("t1_rf_en_busy", rf_en, 0);
        tick(); settle();
        chk("t1_pulse", fdiv_en, 0);
        fdiv_done = 1'b1; tick(); fdiv_done = 1'b0;

        // rob 3 waits on p20, rob 4 ready; rob 4 wins, rob 3 waits for done
        dis_div = 1'b0; dis_db = 1'b0; dis_rm = 3'b111;
        dispatch(6'd3, 7'd11, 7'd20, 7'd21, 1'b0, 1'b1);
        settle();
        chk("t2_not_ready", rf_en, 0);
        dispatch(6'd4, 7'd12, 7'd22, 7'd23, 1'b1, 1'b1);
        wk_en[0] = 1'b1; wk_rd[6:0] = 7'd20;
        settle();
        chk("t2_sel_rob4", rf_en, 1);
        chk("t2_sel_rs1", rf_rs1, 22);
        tick(); wk_en = '0; settle();
        chk("t2_issue4", fdiv_en, 1);
        chk("t2_issue4_rob", fdiv_status.rob_idx, 4);
        chk("t2_rm_dyn", fdiv_rm, 3'b111);
        chk("t2_busy_hold", rf_en, 0);
        tick(); tick(); settle();
        chk("t2_wait", rf_en, 0);
        fdiv_done = 1'b1; settle();
        chk("t2_done_cycle", rf_en, 0);
        tick(); fdiv_done = 1'b0; settle();
        chk("t2_sel_rob3", rf_en, 1);
        chk("t2_sel3_rs1", rf_rs1, 20);
        tick(); settle();
        chk("t2_issue3", fdiv_en, 1);
        chk("t2_issue3_rob", fdiv_status.rob_idx, 3);
        tick(); fdiv_done = 1'b1; tick(); fdiv_done = 1'b0;

        // fill all 8 slots with ops waiting on p40
        for (int k = 0; k < 8; k++) begin
            settle();
            chk("t3_ready_before_full", dis_ready, 1);
            dispatch(6'(16 + k), 7'(30 + k), 7'd40, 7'd41, 1'b0, 1'b1);
        end
        settle();
        chk("t3_full", dis_ready, 0);
        wake(2, 7'd40); settle();
        chk("t3_sel", rf_en, 1);
        chk("t3_full_during_sel", dis_ready, 0);
        tick(); settle();
        chk("t3_freed", dis_ready, 1);
        chk("t3_issue", fdiv_en, 1);
        chk("t3_oldest", fdiv_status.rob_idx, 16);
        tick();
        redirect = 1'b1; redirect_idx = 6'd16;
        tick(); redirect = 1'b0; settle();
        chk("t3_flush_ready", dis_ready, 1);
        chk("t3_flush_empty", rf_en, 0);

        // redirect 10: entries 8,10,12 waiting, S1 holds 11
        dispatch(6'd8, 7'd50, 7'd50, 7'd51, 1'b0, 1'b1);
        dispatch(6'd10, 7'd52, 7'd50, 7'd51, 1'b0, 1'b1);
        dispatch(6'd12, 7'd54, 7'd50, 7'd51, 1'b0, 1'b1);
        dispatch(6'd11, 7'd53, 7'd55, 7'd56, 1'b1, 1'b1);
        settle();
        chk("t4_sel11", rf_en, 1);
        chk("t4_sel11_rs1", rf_rs1, 55);
        tick(); settle();
        chk("t4_pre_redirect", fdiv_en, 1);
        redirect = 1'b1; redirect_idx = 6'd10; settle();
        chk("t4_s1_squash", fdiv_en, 0);
        chk("t4_no_sel", rf_en, 0);
        tick(); redirect = 1'b0;
        wake(1, 7'd50); settle();
        chk("t4_survivor_sel", rf_en, 1);
        tick(); settle();
        chk("t4_issue8", fdiv_en, 1);
        chk("t4_issue8_rob", fdiv_status.rob_idx, 8);
        tick(); fdiv_done = 1'b1; tick(); fdiv_done = 1'b0; settle();
        chk("t4_10_12_flushed", rf_en, 0);

        // ROB wrap: 0x3E is older than 0x00, 0x01 is not
        dispatch(6'h3E, 7'd60, 7'd60, 7'd61, 1'b0, 1'b1);
        dispatch(6'h01, 7'd62, 7'd60, 7'd61, 1'b0, 1'b1);
        redirect = 1'b1; redirect_idx = 6'h00;
        tick(); redirect = 1'b0;
        wake(3, 7'd60); settle();
        chk("t5_sel", rf_en, 1);
        tick(); settle();
        chk("t5_issue", fdiv_en, 1);
        chk("t5_rob3e", fdiv_status.rob_idx, 6'h3E);
        chk("t5_rd", fdiv_status.rd, 60);
        tick(); fdiv_done = 1'b1; tick(); fdiv_done = 1'b0; settle();
        chk("t5_01_flushed", rf_en, 0);

        // reset while S1 is valid
        dispatch(6'd9, 7'd63, 7'd64, 7'd65, 1'b0, 1'b1);
        dispatch(6'd7, 7'd66, 7'd67, 7'd68, 1'b1, 1'b1);
        settle();
        chk("t6_sel", rf_en, 1);
        tick(); settle();
        chk("t6_issue", fdiv_en, 1);
        rst = 1'b0; #1;
        chk("t6_rst_fdiv_en", fdiv_en, 0);
        chk("t6_rst_rf_en", rf_en, 0);
        chk("t6_rst_dis_ready", dis_ready, 1);
        chk("t6_rst_status", fdiv_status, 0);
        tick(); rst = 1'b1;
        wake(0, 7'd64); settle();
        chk("t6_queue_empty", rf_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
